// File: rtl/adc_pipe_decimator.sv
// Output decimator for the 3-bit pipelined ADC: drops pipeline-flush samples after
// enable, sums fixed 2^LOG2_N windows and hands each result out over valid/ready.
module adc_pipe_decimator #(
  parameter int LOG2_N = 3,
  parameter int SKIP   = 2
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              enable_i,
  input  logic [2:0]        d_i,
  input  logic              ready_i,
  input  logic              clear_i,
  output logic              valid_o,
  output logic [2+LOG2_N:0] sum_o,
  output logic [2:0]        avg_o,
  output logic              busy_o,
  output logic              overrun_o
);
  localparam int SW = 3 + LOG2_N;
  localparam logic [SW-1:0] HALF = SW'(1) << (LOG2_N - 1);

  typedef enum logic [1:0] {IDLE, FLUSH, ACCUM} state_t;

  state_t            state, state_n;
  logic [3:0]        fcnt, fcnt_n;
  logic [SW-1:0]     acc, acc_n, sum_w, rnd_w;
  logic [LOG2_N-1:0] cnt, cnt_n;
  logic              do_acc, win_done, xfer, load, drop;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state  <= IDLE;
      fcnt   <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy_o <= 1'b0;
    end else begin
      state  <= state_n;
      fcnt   <= fcnt_n;
      acc    <= acc_n;
      cnt    <= cnt_n;
      busy_o <= (state_n != IDLE);
    end
  end

  // The enabling edge itself is the first discarded sample, so FLUSH only
  // has to cover the remaining SKIP-1 clocks.
  always_comb begin
    state_n = state;
    fcnt_n  = fcnt;
    acc_n   = acc;
    cnt_n   = cnt;
    do_acc  = 1'b0;
    if (!enable_i) begin
      state_n = IDLE;
      fcnt_n  = '0;
      acc_n   = '0;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (SKIP == 0) begin
            do_acc  = 1'b1;
            state_n = ACCUM;
          end else if (SKIP == 1) begin
            state_n = ACCUM;
          end else begin
            state_n = FLUSH;
            fcnt_n  = 4'd1;
          end
        end
        FLUSH: begin
          if (fcnt == 4'(SKIP - 1)) begin
            state_n = ACCUM;
            fcnt_n  = '0;
          end else begin
            fcnt_n = fcnt + 4'd1;
          end
        end
        ACCUM:   do_acc = 1'b1;
        default: state_n = IDLE;
      endcase
    end
    sum_w    = acc + SW'(d_i);
    rnd_w    = sum_w + HALF;
    win_done = do_acc && (cnt == '1);
    if (do_acc) begin
      cnt_n = cnt + 1'b1;
      acc_n = win_done ? '0 : sum_w;
    end
  end

  assign xfer = valid_o && ready_i;
  assign load = win_done && (!valid_o || ready_i);
  assign drop = win_done && valid_o && !ready_i;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      valid_o   <= 1'b0;
      sum_o     <= '0;
      avg_o     <= '0;
      overrun_o <= 1'b0;
    end else begin
      if (load) begin
        valid_o <= 1'b1;
        sum_o   <= sum_w;
        avg_o   <= rnd_w[LOG2_N +: 3];
      end else if (xfer) begin
        valid_o <= 1'b0;
      end
      // A drop on the same edge as a clear must leave the flag set.
      if (drop)         overrun_o <= 1'b1;
      else if (clear_i) overrun_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_adc_pipe_decimator.sv
// Scoreboard bench for adc_pipe_decimator: one DUT at LOG2_N=3/SKIP=2, one at LOG2_N=1/SKIP=0.
module tb_adc_pipe_decimator;
  typedef struct {
    logic [5:0] sum;
    logic [2:0] avg;
  } res_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, rdy, clr, en1, rdy1, clr1;
  logic [2:0] d, d1;
  logic       v, busy, ovr, v1, busy1, ovr1;
  logic [5:0] sum;
  logic [3:0] sum1;
  logic [2:0] avg, avg1;
  int         checks = 0;
  int         failures = 0;
  res_t       sb[$];

  always #5 clk = ~clk;

  adc_pipe_decimator #(.LOG2_N(3), .SKIP(2)) u_dut (
    .clock_i(clk), .reset_i(rst), .enable_i(en), .d_i(d), .ready_i(rdy), .clear_i(clr),
    .valid_o(v), .sum_o(sum), .avg_o(avg), .busy_o(busy), .overrun_o(ovr));

  adc_pipe_decimator #(.LOG2_N(1), .SKIP(0)) u_dut1 (
    .clock_i(clk), .reset_i(rst), .enable_i(en1), .d_i(d1), .ready_i(rdy1), .clear_i(clr1),
    .valid_o(v1), .sum_o(sum1), .avg_o(avg1), .busy_o(busy1), .overrun_o(ovr1));

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; en1 = 1'b0; rdy = 1'b0; rdy1 = 1'b0;
    clr = 1'b0; clr1 = 1'b0; d = 3'd0; d1 = 3'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; en1 = 1'b1; rdy = 1'b1; rdy1 = 1'b1;
    clr = 1'b0; clr1 = 1'b0; d = 3'd5; d1 = 3'd5;
    #3;
    checks++; if ({v, sum, avg, busy, ovr} !== 12'd0) begin
      failures++; $display("FAIL reset_async got v=%b sum=%0d avg=%0d busy=%b ovr=%b exp all 0", v, sum, avg, busy, ovr);
    end
    checks++; if ({v1, sum1, avg1, busy1, ovr1} !== 10'd0) begin
      failures++; $display("FAIL reset_async_b got v=%b sum=%0d avg=%0d busy=%b ovr=%b exp all 0", v1, sum1, avg1, busy1, ovr1);
    end
    repeat (3) @(negedge clk);
    checks++; if ({v, sum, avg, busy, ovr} !== 12'd0) begin
      failures++; $display("FAIL reset_held got v=%b sum=%0d avg=%0d busy=%b ovr=%b exp all 0", v, sum, avg, busy, ovr);
    end
  endtask

  task automatic test_basic();
    res_t e;
    do_reset();
    en = 1'b1; rdy = 1'b1; d = 3'd5;
    for (int k = 0; k < 20; k++) begin
      if (k == 9 || k == 17) begin e.sum = 6'd40; e.avg = 3'd5; sb.push_back(e); end
      @(negedge clk);
      if (k == 0) begin
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", busy); end
      end
      checks++; if (v !== (k == 9 || k == 17)) begin
        failures++; $display("FAIL basic_valid edge=%0d got=%b exp=%b", k, v, (k == 9 || k == 17));
      end
      if (v) begin
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL basic_unexpected edge=%0d got sum=%0d exp none", k, sum); end
        else begin
          e = sb.pop_front();
          if (sum !== e.sum || avg !== e.avg) begin
            failures++; $display("FAIL basic_result edge=%0d got sum=%0d avg=%0d exp sum=%0d avg=%0d", k, sum, avg, e.sum, e.avg);
          end
        end
      end
    end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL basic_missing got=%0d left exp=0", sb.size()); end
  endtask

  task automatic test_rounding();
    res_t e;
    int   j, w, i;
    logic [5:0] es[4] = '{6'd28, 6'd4, 6'd56, 6'd0};
    logic [2:0] ea[4] = '{3'd4, 3'd1, 3'd7, 3'd0};
    do_reset();
    en = 1'b1; rdy = 1'b1;
    for (int k = 0; k < 36; k++) begin
      j = k - 2; w = j / 8; i = j % 8;
      if (k < 2) d = 3'd6;
      else case (w)
        0:       d = (i % 2 == 0) ? 3'd3 : 3'd4;
        1:       d = (i == 7) ? 3'd4 : 3'd0;
        2:       d = 3'd7;
        default: d = 3'd0;
      endcase
      if (k >= 2 && i == 7) begin e.sum = es[w]; e.avg = ea[w]; sb.push_back(e); end
      @(negedge clk);
      checks++; if (v !== (k >= 2 && i == 7)) begin
        failures++; $display("FAIL round_valid edge=%0d got=%b exp=%b", k, v, (k >= 2 && i == 7));
      end
      if (v) begin
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL round_unexpected edge=%0d got sum=%0d exp none", k, sum); end
        else begin
          e = sb.pop_front();
          if (sum !== e.sum || avg !== e.avg) begin
            failures++; $display("FAIL round_result edge=%0d got sum=%0d avg=%0d exp sum=%0d avg=%0d", k, sum, avg, e.sum, e.avg);
          end
        end
      end
    end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL round_missing got=%0d left exp=0", sb.size()); end
  endtask

  task automatic test_backpressure();
    res_t e;
    do_reset();
    en = 1'b1; rdy = 1'b0;
    for (int k = 0; k < 27; k++) begin
      d = (k < 2) ? 3'd0 : (k < 10) ? 3'd5 : 3'd1;
      clr = (k == 18 || k == 25);
      rdy = (k == 26);
      if (k == 9) begin e.sum = 6'd40; e.avg = 3'd5; sb.push_back(e); end
      @(negedge clk);
      checks++; if (v !== (k >= 9 && k < 26)) begin
        failures++; $display("FAIL bp_valid edge=%0d got=%b exp=%b", k, v, (k >= 9 && k < 26));
      end
      if (k == 17 || k == 25) begin
        checks++; if (sum !== 6'd40 || avg !== 3'd5) begin
          failures++; $display("FAIL bp_held edge=%0d got sum=%0d avg=%0d exp sum=40 avg=5", k, sum, avg);
        end
      end
      checks++; if (ovr !== ((k >= 17 && k < 18) || k >= 25)) begin
        failures++; $display("FAIL bp_overrun edge=%0d got=%b exp=%b", k, ovr, ((k >= 17 && k < 18) || k >= 25));
      end
      if (k == 25) begin
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL bp_unexpected edge=%0d got sum=%0d exp none", k, sum); end
        else begin
          e = sb.pop_front();
          if (sum !== e.sum || avg !== e.avg) begin
            failures++; $display("FAIL bp_result got sum=%0d avg=%0d exp sum=%0d avg=%0d", sum, avg, e.sum, e.avg);
          end
        end
      end
    end
    clr = 1'b0; rdy = 1'b0;
  endtask

  task automatic test_enable_drop();
    res_t e;
    do_reset();
    rdy = 1'b1;
    for (int k = 0; k < 22; k++) begin
      en = !(k >= 7 && k <= 9);
      d  = (k >= 12) ? 3'd2 : 3'd7;
      if (k == 19) begin e.sum = 6'd16; e.avg = 3'd2; sb.push_back(e); end
      @(negedge clk);
      if (k == 7 || k == 10) begin
        checks++; if (busy !== (k == 10)) begin failures++; $display("FAIL en_busy edge=%0d got=%b exp=%b", k, busy, (k == 10)); end
      end
      checks++; if (v !== (k == 19)) begin
        failures++; $display("FAIL en_valid edge=%0d got=%b exp=%b", k, v, (k == 19));
      end
      if (v) begin
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL en_unexpected edge=%0d got sum=%0d exp none", k, sum); end
        else begin
          e = sb.pop_front();
          if (sum !== e.sum || avg !== e.avg) begin
            failures++; $display("FAIL en_result got sum=%0d avg=%0d exp sum=%0d avg=%0d", sum, avg, e.sum, e.avg);
          end
        end
      end
    end
  endtask

  task automatic test_async_reset();
    res_t e;
    do_reset();
    en = 1'b1; rdy = 1'b0; d = 3'd4;
    for (int k = 0; k < 12; k++) @(negedge clk);
    checks++; if (v !== 1'b1 || sum !== 6'd32) begin
      failures++; $display("FAIL ar_pending got v=%b sum=%0d exp v=1 sum=32", v, sum);
    end
    #2 rst = 1'b1;
    #1;
    checks++; if ({v, sum, avg, busy, ovr} !== 12'd0) begin
      failures++; $display("FAIL ar_immediate got v=%b sum=%0d avg=%0d busy=%b ovr=%b exp all 0", v, sum, avg, busy, ovr);
    end
    @(negedge clk);
    rst = 1'b0; rdy = 1'b1; d = 3'd3;
    for (int k = 0; k < 12; k++) begin
      if (k == 9) begin e.sum = 6'd24; e.avg = 3'd3; sb.push_back(e); end
      @(negedge clk);
      checks++; if (v !== (k == 9)) begin
        failures++; $display("FAIL ar_valid edge=%0d got=%b exp=%b", k, v, (k == 9));
      end
      if (v) begin
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL ar_unexpected edge=%0d got sum=%0d exp none", k, sum); end
        else begin
          e = sb.pop_front();
          if (sum !== e.sum || avg !== e.avg) begin
            failures++; $display("FAIL ar_result got sum=%0d avg=%0d exp sum=%0d avg=%0d", sum, avg, e.sum, e.avg);
          end
        end
      end
    end
  endtask

  task automatic test_skip0();
    res_t e;
    logic [2:0] pat[4] = '{3'd6, 3'd7, 3'd1, 3'd0};
    do_reset();
    en1 = 1'b1; rdy1 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      d1 = (k < 4) ? pat[k] : 3'd0;
      if (k == 1) begin e.sum = 6'd13; e.avg = 3'd7; sb.push_back(e); end
      if (k == 3) begin e.sum = 6'd1;  e.avg = 3'd1; sb.push_back(e); end
      @(negedge clk);
      checks++; if (v1 !== (k == 1 || k == 3)) begin
        failures++; $display("FAIL skip0_valid edge=%0d got=%b exp=%b", k, v1, (k == 1 || k == 3));
      end
      if (v1) begin
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL skip0_unexpected edge=%0d got sum=%0d exp none", k, sum1); end
        else begin
          e = sb.pop_front();
          if (sum1 !== e.sum[3:0] || avg1 !== e.avg) begin
            failures++; $display("FAIL skip0_result edge=%0d got sum=%0d avg=%0d exp sum=%0d avg=%0d", k, sum1, avg1, e.sum, e.avg);
          end
        end
      end
    end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL skip0_missing got=%0d left exp=0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_backpressure();
    test_enable_drop();
    test_async_reset();
    test_skip0();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/adc_pipe_decimator.md
# adc_pipe_decimator

Output decimator for the 3-bit pipelined ADC. It takes the corrected code produced each clock by the pipeline encoder and discards the first samples after enable, which are pipeline-flush garbage. It then averages fixed windows of 2^LOG2_N codes and presents each window result to the digital back-end over a valid/ready handshake, with a sticky overrun flag.

## Interface
- LOG2_N, 3: log2 of window length N; legal range 1..8.
- SKIP, 2: samples discarded after each enable rising edge (pipeline latency); legal range 0..15.
- clock_i  input  1  sample clock, same clock as the encoder output register.
- reset_i  input  1  asynchronous, active-high reset.
- enable_i  input  1  conversion enable; low forces the idle state.
- d_i  input  3  corrected ADC code from the encoder, unsigned 0..7, one new sample per clock.
- ready_i  input  1  consumer accepts the result when high together with valid_o.
- clear_i  input  1  clears overrun_o.
- valid_o  output  1  result registers hold an unconsumed window result.
- sum_o  output  3+LOG2_N  full-precision window sum.
- avg_o  output  3  rounded window mean.
- busy_o  output  1  high in FLUSH or ACCUM.
- overrun_o  output  1  sticky flag: a completed window was dropped.

## Operation
- Three-state FSM: IDLE, FLUSH, ACCUM.
  - IDLE -> FLUSH when enable_i=1 (SKIP>0). Goes directly to ACCUM when SKIP=0.
  - FLUSH: counts SKIP clocks with enable_i high and ignores d_i, then moves to ACCUM.
  - ACCUM: every clock adds d_i into the accumulator acc and increments sample counter cnt (LOG2_N bits, wraps).
  - Any state -> IDLE on the edge where enable_i=0. Partial acc/cnt are discarded (cleared to 0). Held result, valid_o and overrun_o are unaffected.
- Window completion happens on the edge that adds the Nth sample (cnt = N-1):
  - sum = acc + d_i, width 3+LOG2_N, never overflows (max 7N).
  - avg = (sum + 2^(LOG2_N-1)) >> LOG2_N, i.e. round-half-up. Max value is 7, so no saturation is needed.
  - acc and cnt restart at 0. The next clock's sample is the first of the next window, so windows are back-to-back with no gap.
- Output register loading at window completion:
  - If valid_o=0, or valid_o=1 and ready_i=1 on that edge, load sum_o/avg_o and keep or set valid_o=1.
  - If valid_o=1 and ready_i=0, drop the new result: sum_o/avg_o are unchanged and overrun_o is set.
- Handshake:
  - Transfer occurs on an edge with valid_o=1 and ready_i=1.
  - valid_o falls after a transfer unless a new result loads on the same edge.
  - sum_o/avg_o stay stable while valid_o=1 and no transfer occurs.
- clear_i clears overrun_o on the next edge. If a set and a clear coincide, set wins.
- busy_o = (state != IDLE), registered.

## Timing
- Reset (asynchronous, immediate): state IDLE; acc=0; cnt=0; FLUSH counter 0; valid_o=0; sum_o=0; avg_o=0; busy_o=0; overrun_o=0.
- With enable_i rising before edge 0: edges 0..SKIP-1 are skipped, and edges SKIP..SKIP+N-1 are accumulated.
- valid_o and the result are visible after edge SKIP+N-1; latency is SKIP+N clocks from the enable edge. Each later window completes exactly N clocks after the previous one.
- Reset mid-window or mid-handshake aborts everything, including any pending result. No output is produced until a fresh FLUSH completes.
- Enable toggled low then high restarts FLUSH with the full SKIP count.
- ready_i may be held high permanently; each result is then valid for exactly one clock, with back-to-back valids only if N=... (never for N>=2).

## Test plan
- LOG2_N=3, SKIP=2, d_i=5 constant, ready_i=1, enable_i rises before edge 0 -> valid_o is high for one clock after edge 9 with sum_o=40, avg_o=5. Next valid follows after edge 17.
- Rounding: window d_i alternating 3,4 -> sum_o=28, avg_o=4. Window of seven 0s and one 4 -> sum_o=4, avg_o=1 (half rounds up). All 7 -> sum_o=56, avg_o=7. All 0 -> 0/0.
- Backpressure: ready_i=0 across two completions -> the first result is held, the second is dropped, and overrun_o=1. Then clear_i pulse -> overrun_o=0. clear_i coincident with a drop -> overrun_o stays 1.
- Enable drop: enable_i=0 after 5 accumulated samples, re-raised 3 clocks later -> no result from the partial window. The next result uses only post-FLUSH samples, arriving SKIP+N clocks after re-enable.
- Reset asserted asynchronously mid-ACCUM with valid_o=1 -> all outputs 0 immediately. After release with enable high, the first result appears SKIP+N clocks later.
- SKIP=0, LOG2_N=1, d_i sequence 6,7 -> sum_o=13, avg_o=7 after the second edge.
